// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and FSM encoding for the TLC549 averaging path
package adc_pkg;
  localparam int ADC_FRAME_CLKS      = 1402;
  localparam int ADC_CAPTURE_OFS     = 1000;
  localparam int ADC_VREF_MV_DEFAULT = 3300;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_SCALE   = 2'd2,
    ST_CONVERT = 2'd3
  } adc_state_e;
endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 converter, 12-bit binary to 4 BCD digits, 1 bit/clk
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        done
);
  logic [11:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = 4'd0;
    end else if (start) begin
      bin_d = bin;
      bcd_d = 16'h0000;
      cnt_d = 4'd12;
    end else if (cnt_q != 4'd0) begin
      bcd_d = 16'({adj, bin_q[11]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 4'd1;
    end
  end

  // The final digits are presented combinationally so the caller can latch them in the done cycle.
  assign bcd  = bcd_d;
  assign done = (cnt_q == 4'd1) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/adc_avg_mv.sv
// rtl/adc_avg_mv.sv - per-frame ADC capture, block average, mV scaling and BCD for the display mux
module adc_avg_mv
  import adc_pkg::*;
#(
  parameter int FRAME_CLKS  = ADC_FRAME_CLKS,
  parameter int CAPTURE_OFS = ADC_CAPTURE_OFS,
  parameter int AVG_LOG2    = 3,
  parameter int VREF_MV     = ADC_VREF_MV_DEFAULT
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic        enable,
  output logic        ad_enable,
  input  logic [7:0]  ad_data,
  output logic [7:0]  avg_code,
  output logic [15:0] mv_bcd,
  output logic        result_valid,
  output logic        busy
);
  localparam int FC_W   = $clog2(FRAME_CLKS);
  localparam int ACC_W  = 8 + AVG_LOG2;
  localparam int SC_W   = AVG_LOG2 + 1;
  localparam int PROD_W = 8 + 14;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_CLKS - 1);
  localparam logic [FC_W-1:0] CAP_POS    = FC_W'(CAPTURE_OFS);
  localparam logic [SC_W-1:0] SC_FULL    = SC_W'(2 ** AVG_LOG2);

  adc_state_e        state_q, state_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SC_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]        mean_q, mean_d;
  logic [7:0]        avg_code_q, avg_code_d;
  logic [15:0]       mv_bcd_q, mv_bcd_d;
  logic              result_valid_q, result_valid_d;

  logic              capture;
  logic [ACC_W-1:0]  acc_sum;
  logic [7:0]        mean;
  logic [PROD_W-1:0] prod;
  logic [11:0]       mv;
  logic              bcd_start;
  logic              bcd_done;
  logic [15:0]       bcd_val;

  assign capture = (state_q != ST_IDLE) && (frame_cnt_q == CAP_POS);
  assign acc_sum = acc_q + ACC_W'(ad_data);
  assign mean    = 8'(acc_q >> AVG_LOG2);
  assign prod    = PROD_W'(mean) * PROD_W'(VREF_MV);
  assign mv      = 12'(prod >> 8);

  bin2bcd_seq u_bcd (
    .clk   (CLOCK_50),
    .rst_n (RST_N),
    .start (bcd_start),
    .abort (!enable),
    .bin   (mv),
    .bcd   (bcd_val),
    .done  (bcd_done)
  );

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    acc_d          = acc_q;
    mean_d         = mean_q;
    avg_code_d     = avg_code_q;
    mv_bcd_d       = mv_bcd_q;
    result_valid_d = 1'b0;
    bcd_start      = 1'b0;

    if (state_q != ST_IDLE) begin
      frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FC_W'(1);
    end
    // Captures are taken in every running state, including while a conversion is in flight.
    if (capture) begin
      acc_d        = acc_sum;
      sample_cnt_d = sample_cnt_q + SC_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_ACCUM;
          frame_cnt_d  = '0;
          acc_d        = '0;
          sample_cnt_d = '0;
        end
      end
      ST_ACCUM: begin
        if (sample_cnt_d == SC_FULL) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        mean_d       = mean;
        bcd_start    = 1'b1;
        acc_d        = capture ? ACC_W'(ad_data) : '0;
        sample_cnt_d = capture ? SC_W'(1) : '0;
        state_d      = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (bcd_done) begin
          avg_code_d     = mean_q;
          mv_bcd_d       = bcd_val;
          result_valid_d = 1'b1;
          state_d        = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable discards everything in flight but keeps the last displayed result.
    if (!enable) begin
      state_d        = ST_IDLE;
      frame_cnt_d    = '0;
      sample_cnt_d   = '0;
      acc_d          = '0;
      avg_code_d     = avg_code_q;
      mv_bcd_d       = mv_bcd_q;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= '0;
      sample_cnt_q   <= '0;
      acc_q          <= '0;
      mean_q         <= '0;
      avg_code_q     <= '0;
      mv_bcd_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      acc_q          <= acc_d;
      mean_q         <= mean_d;
      avg_code_q     <= avg_code_d;
      mv_bcd_q       <= mv_bcd_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign ad_enable    = (state_q != ST_IDLE);
  assign busy         = (state_q == ST_SCALE) || (state_q == ST_CONVERT);
  assign avg_code     = avg_code_q;
  assign mv_bcd       = mv_bcd_q;
  assign result_valid = result_valid_q;
endmodule

// File: tb/tb_adc_avg_mv.sv
// tb/tb_adc_avg_mv.sv - bench for adc_avg_mv with ADC driver model and block-average reference
module tb_adc_avg_mv;
  localparam int F    = 1402;
  localparam int CAP  = 1000;
  localparam int UPD  = 406;
  localparam int VREF = 3300;
  localparam int LAT  = 14;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [1:0]       tb_rst_n;
  logic [1:0]       en;
  logic [1:0][7:0]  ad;
  logic [1:0]       ad_en;
  logic [1:0][7:0]  avg;
  logic [1:0][15:0] bcd;
  logic [1:0]       rv;
  logic [1:0]       bsy;

  adc_avg_mv #(.AVG_LOG2(3)) u0 (
    .CLOCK_50(CLOCK_50), .RST_N(tb_rst_n[0]), .enable(en[0]), .ad_enable(ad_en[0]),
    .ad_data(ad[0]), .avg_code(avg[0]), .mv_bcd(bcd[0]), .result_valid(rv[0]), .busy(bsy[0])
  );
  adc_avg_mv #(.AVG_LOG2(2)) u1 (
    .CLOCK_50(CLOCK_50), .RST_N(tb_rst_n[1]), .enable(en[1]), .ad_enable(ad_en[1]),
    .ad_data(ad[1]), .avg_code(avg[1]), .mv_bcd(bcd[1]), .result_valid(rv[1]), .busy(bsy[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int act = 0;
  int log2n [2];
  int fr [2];
  logic prev_en [2];

  // Reference model state for the active instance.
  logic [7:0] feed [$];
  int pend [$];
  int exp_cyc [$];
  int exp_avg [$];
  int exp_bcd [$];
  int rcount = 0;
  int caps = 0;
  int last_cap = 0;
  int last_rv_cyc = 0;
  int c0 = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_abort();
    pend.delete();
    exp_cyc.delete();
    exp_avg.delete();
    exp_bcd.delete();
    feed.delete();
  endtask

  task automatic tick();
    int sum;
    int mean;
    logic due;
    @(posedge CLOCK_50);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (ad_en[i]) fr[i] = prev_en[i] ? (fr[i] + 1) % F : 0;
      else fr[i] = 0;
      prev_en[i] = ad_en[i];
    end
    if (ad_en[act]) begin
      if (fr[act] == UPD && feed.size() > 0) ad[act] = feed.pop_front();
      if (fr[act] == CAP) begin
        pend.push_back(int'(ad[act]));
        caps++;
        last_cap = cyc;
        if (pend.size() == (1 << log2n[act])) begin
          sum = 0;
          foreach (pend[k]) sum += pend[k];
          mean = sum / pend.size();
          exp_cyc.push_back(cyc + LAT);
          exp_avg.push_back(mean);
          exp_bcd.push_back(int'(to_bcd(mean * VREF / 256)));
          pend.delete();
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      due = (i == act) && (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
      if (rv[i] || due) begin
        chk($sformatf("result_valid_u%0d_cyc%0d", i, cyc), rv[i], due);
        if (due) begin
          chk($sformatf("avg_code_u%0d_cyc%0d", i, cyc), avg[i], exp_avg[0]);
          chk($sformatf("mv_bcd_u%0d_cyc%0d", i, cyc), bcd[i], exp_bcd[0]);
          void'(exp_cyc.pop_front());
          void'(exp_avg.pop_front());
          void'(exp_bcd.pop_front());
          rcount++;
          last_rv_cyc = cyc;
        end
      end
    end
  endtask

  task automatic run_until_results(input int target, input int budget);
    int n;
    n = 0;
    while (rcount < target && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("results_reached_%0d", target), 32'(rcount >= target), 1);
  endtask

  task automatic run_until_caps(input int target, input int budget);
    int n;
    n = 0;
    while (caps < target && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("captures_reached_%0d", target), 32'(caps >= target), 1);
  endtask

  initial begin
    int t_prev;
    int cap4;
    int r [4];
    int rsum;
    tb_rst_n = 2'b00;
    en = 2'b00;
    ad = '0;
    log2n[0] = 3;
    log2n[1] = 2;
    fr[0] = 0;
    fr[1] = 0;
    prev_en[0] = 1'b0;
    prev_en[1] = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ad_enable_u%0d", i), ad_en[i], 0);
      chk($sformatf("reset_avg_code_u%0d", i), avg[i], 0);
      chk($sformatf("reset_mv_bcd_u%0d", i), bcd[i], 0);
      chk($sformatf("reset_result_valid_u%0d", i), rv[i], 0);
      chk($sformatf("reset_busy_u%0d", i), bsy[i], 0);
    end
    tb_rst_n = 2'b11;
    repeat (3) tick();

    // Constant 0x80 for two blocks, then 0xFF, then five random samples that get aborted.
    act = 0;
    repeat (16) feed.push_back(8'h80);
    repeat (8) feed.push_back(8'hFF);
    repeat (5) feed.push_back(8'($urandom_range(0, 255)));
    en[0] = 1'b1;
    tick();
    chk("ad_enable_rise", ad_en[0], 1);
    c0 = cyc;
    run_until_results(1, 12000);
    chk("first_result_latency", last_rv_cyc - c0, 7 * F + CAP + LAT);
    chk("avg_0x80", avg[0], 128);
    chk("mv_0x80", bcd[0], 16'h1650);
    t_prev = last_rv_cyc;
    tick();
    chk("pulse_width", rv[0], 0);
    run_until_results(2, 12000);
    chk("result_period", last_rv_cyc - t_prev, 8 * F);
    run_until_results(3, 12000);
    chk("avg_0xFF", avg[0], 255);
    chk("mv_0xFF", bcd[0], 16'h3287);

    // Abort after 5 of 8 captures.
    run_until_caps(29, 8000);
    repeat (10) tick();
    chk("busy_in_accum", bsy[0], 0);
    en[0] = 1'b0;
    model_abort();
    tick();
    chk("ad_enable_drop", ad_en[0], 0);
    repeat (3000) tick();
    chk("no_result_while_disabled", rcount, 3);
    chk("hold_avg_after_abort", avg[0], 255);
    chk("hold_mv_after_abort", bcd[0], 16'h3287);

    // Restart: the first result must come from 8 fresh frames only.
    repeat (8) feed.push_back(8'h40);
    en[0] = 1'b1;
    tick();
    chk("ad_enable_rerise", ad_en[0], 1);
    c0 = cyc;
    run_until_results(4, 12000);
    chk("restart_latency", last_rv_cyc - c0, 7 * F + CAP + LAT);
    chk("avg_0x40", avg[0], 64);
    chk("mv_0x40", bcd[0], 16'h0825);
    en[0] = 1'b0;
    model_abort();
    repeat (50) tick();
    chk("hold_avg_idle", avg[0], 64);

    // Second instance, four samples per average.
    act = 1;
    rcount = 0;
    caps = 0;
    rsum = 0;
    feed.push_back(8'd10);
    feed.push_back(8'd20);
    feed.push_back(8'd30);
    feed.push_back(8'd40);
    repeat (4) feed.push_back(8'd0);
    for (int k = 0; k < 4; k++) begin
      r[k] = int'($urandom_range(0, 255));
      rsum += r[k];
      feed.push_back(8'(r[k]));
    end
    repeat (4) feed.push_back(8'($urandom_range(0, 255)));
    en[1] = 1'b1;
    tick();
    chk("u1_ad_enable_rise", ad_en[1], 1);
    run_until_caps(4, 6000);
    cap4 = last_cap;
    repeat (5) tick();
    chk("u1_busy_convert", bsy[1], 1);
    run_until_results(1, 100);
    chk("u1_latency_after_4th", last_rv_cyc - cap4, LAT);
    chk("u1_avg_25", avg[1], 25);
    chk("u1_mv_322", bcd[1], 16'h0322);
    tick();
    chk("u1_pulse_width", rv[1], 0);
    run_until_results(2, 6000);
    chk("u1_avg_zero", avg[1], 0);
    chk("u1_mv_zero", bcd[1], 16'h0000);
    run_until_results(3, 6000);
    chk("u1_avg_random", avg[1], rsum / 4);
    chk("u1_mv_random", bcd[1], to_bcd((rsum / 4) * VREF / 256));

    // Asynchronous reset in the middle of a conversion.
    run_until_caps(16, 6000);
    repeat (6) tick();
    chk("u1_busy_before_reset", bsy[1], 1);
    tb_rst_n[1] = 1'b0;
    #1;
    chk("u1_rst_ad_enable", ad_en[1], 0);
    chk("u1_rst_avg_code", avg[1], 0);
    chk("u1_rst_mv_bcd", bcd[1], 0);
    chk("u1_rst_result_valid", rv[1], 0);
    chk("u1_rst_busy", bsy[1], 0);
    en[1] = 1'b0;
    model_abort();
    repeat (40) tick();
    tb_rst_n[1] = 1'b1;
    repeat (20) tick();
    chk("u1_no_result_after_reset", rcount, 3);
    chk("u1_avg_after_reset", avg[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
